mips_fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_fetch_stage_if_id_reg.sv | 43 ++++
 rtl/mips_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_mips_fetch_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and word widths.
// Used by the fetch stage and by controlUnit.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mips_fetch_stage_if_id_reg.sv
// IF/ID pipeline register holding {valid, instr, pc4}.
// Flush beats load; an invalid entry always carries a zero instruction word.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] new_instr,
    input  logic [ADDR_W-1:0]  new_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc4
);

    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc4_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc4_reg   <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc4_reg   <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= new_instr;
            pc4_reg   <= new_pc4;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc4   = pc4_reg;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch with one outstanding imem request, stall, redirect and drain.
// Define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [5:0]         ins_opCode,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] target_reg;

    logic              load_en;
    logic              load_ifid;
    logic              flush_ifid;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_pc;

    assign load_en   = !if_id_valid || !id_stall;
    assign pc_plus4  = pc_reg + PC_STEP;
    assign branch_pc = branch_target & ALIGN_MASK;

    // Request is withheld while decode is stalled, so a response can never
    // arrive with nowhere to go. A drain keeps requesting the abandoned pc.
    assign imem_req  = ((state_reg == S_FETCH) && load_en) || (state_reg == S_DRAIN);
    assign imem_addr = pc_reg;

    assign load_ifid = (state_reg == S_FETCH) && imem_req && imem_ready && !branch_taken;

    // An entry that decode takes this cycle and is not replaced becomes a bubble.
    assign flush_ifid = branch_taken || (!load_ifid && if_id_valid && !id_stall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            pc_reg     <= RESET_PC;
            target_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_FETCH;
                    if (branch_taken) begin
                        pc_reg <= branch_pc;
                    end
                end
                S_FETCH: begin
                    if (branch_taken) begin
                        if (imem_ready) begin
                            pc_reg <= branch_pc;
                        end else begin
                            target_reg <= branch_pc;
                            state_reg  <= S_DRAIN;
                        end
                    end else if (load_ifid) begin
                        pc_reg <= pc_plus4;
                    end else if (!load_en) begin
                        state_reg <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (branch_taken) begin
                        pc_reg    <= branch_pc;
                        state_reg <= S_FETCH;
                    end else if (load_en) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // The latest redirect wins, even one arriving with the response.
                    if (imem_ready) begin
                        pc_reg    <= branch_taken ? branch_pc : target_reg;
                        state_reg <= S_FETCH;
                    end else if (branch_taken) begin
                        target_reg <= branch_pc;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_ifid),
        .flush    (flush_ifid),
        .new_instr(imem_rdata),
        .new_pc4  (pc_plus4),
        .valid    (if_id_valid),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4)
    );

    assign ins_opCode = if_id_instr[INSTR_W-1:INSTR_W-6];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (load_ifid) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (state_reg == S_STALL) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: directed scenarios plus a randomized run
// checked against a program-order instruction-stream model.
module tb_mips_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [5:0]  ins_opCode;
    logic [31:0] if_id_pc4;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    // Expected program-order PC of the next instruction decode will accept.
    logic [31:0] exp_q[$];

    int mem_lat  = 1;
    int wait_cnt = 0;

    mips_fetch_stage #(
        .ADDR_W  (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .ins_opCode    (ins_opCode),
        .if_id_pc4     (if_id_pc4),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0020;
            32'h4:   return 32'h8C01_0004;
            32'h8:   return 32'hAC01_0008;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Memory: responds on the mem_lat-th consecutive cycle of a held request.
    assign imem_rdata = mem_word(imem_addr);
    assign imem_ready = imem_req && ((wait_cnt + 1) >= mem_lat);

    always @(posedge clk) begin
        if (!imem_req || imem_ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        branch_taken  = 1'b1;
        branch_target = tgt;
        exp_q.delete();
        exp_q.push_back(tgt & ~32'h3);
    endtask

    task automatic do_reset(input int lat);
        rst_n        = 1'b0;
        id_stall     = 1'b0;
        branch_taken = 1'b0;
        mem_lat      = lat;
        sb_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: decode accepts an entry when valid, not stalled and not squashed.
    logic        prev_rst = 1'b1;
    logic        prev_req = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!prev_rst) begin
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_instr", if_id_instr, 32'd0);
            chk("rst_pc4", if_id_pc4, 32'd0);
            chk("rst_perf_f", perf_fetch_cnt, 32'd0);
            chk("rst_perf_s", perf_stall_cnt, 32'd0);
        end
        if (rst_n) begin
            chk("opcode_map", {26'b0, ins_opCode}, {26'b0, if_id_instr[31:26]});
            if (!if_id_valid) chk("bubble_zero", if_id_instr, 32'd0);
            if (prev_rst && prev_req && !prev_rdy && imem_req)
                chk("addr_stable", imem_addr, prev_addr);
            if (if_id_valid && !id_stall && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty actual=entry required=none t=%0t", $time);
                end else begin
                    logic [31:0] p;
                    p = exp_q.pop_front();
                    chk("sb_pc4", if_id_pc4, p + 32'd4);
                    chk("sb_instr", if_id_instr, mem_word(p));
                    exp_q.push_back(p + 32'd4);
                    consumed++;
                end
            end
        end
        prev_rst  = rst_n;
        prev_req  = imem_req;
        prev_rdy  = imem_ready;
        prev_addr = imem_addr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [5:0]  ops [3];
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    initial begin
        ops[0] = 6'b000000;
        ops[1] = 6'b100011;
        ops[2] = 6'b101011;
`ifdef FETCH_PERF_CNT_EN
        exp_fetch = 32'd5;
        exp_stall = 32'd4;
`else
        exp_fetch = 32'd0;
        exp_stall = 32'd0;
`endif
        rst_n         = 1'b0;
        id_stall      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;

        // Zero-wait streaming, then a 4-cycle decode stall.
        do_reset(1);
        @(negedge clk);
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("zw_addr0", imem_addr, 32'd0);
        chk("zw_req0", {31'b0, imem_req}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("zw_opcode", {26'b0, ins_opCode}, {26'b0, ops[k]});
            chk("zw_pc4", if_id_pc4, 32'(4 * k + 4));
            chk("zw_addr", imem_addr, 32'(4 * k + 4));
        end
        tick();
        id_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_req", {31'b0, imem_req}, 32'd0);
            chk("st_valid", {31'b0, if_id_valid}, 32'd1);
            chk("st_pc4", if_id_pc4, 32'd16);
            chk("st_addr", imem_addr, 32'd16);
        end
        tick();
        id_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'd16);
        @(negedge clk);
        chk("resume_pc4", if_id_pc4, 32'd20);
        chk("perf_fetch", perf_fetch_cnt, exp_fetch);
        chk("perf_stall", perf_stall_cnt, exp_stall);

        // 3-cycle latency from reset.
        tick();
        do_reset(3);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat_req", {31'b0, imem_req}, 32'd1);
            chk("lat_addr", imem_addr, 32'd0);
            chk("lat_valid", {31'b0, if_id_valid}, 32'd0);
        end
        @(negedge clk);
        chk("lat_valid_up", {31'b0, if_id_valid}, 32'd1);
        chk("lat_pc4", if_id_pc4, 32'd4);

        // Redirect mid-wait at pc=8 (drain), then redirect coincident with ready.
        tick();
        do_reset(1);
        tick();
        tick();
        tick();
        mem_lat = 3;
        tick();
        do_branch(32'h0000_0041);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("drain_valid", {31'b0, if_id_valid}, 32'd0);
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'd8);
        tick();
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        tick();
        do_branch(32'h0000_0100);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("same_addr", imem_addr, 32'h100);
        chk("same_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("tgt_valid", {31'b0, if_id_valid}, 32'd1);
        chk("tgt_pc4", if_id_pc4, 32'h104);
        chk("tgt_instr", if_id_instr, mem_word(32'h100));

        // Reset while a fetch is waiting.
        tick();
        rst_n = 1'b0;
        sb_reset();
        tick();
        @(negedge clk);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, RESET_PC);
        tick();
        rst_n = 1'b1;

        // Wrap-around across the top of the address space.
        do_reset(1);
        do_branch(32'hFFFF_FFFA);
        tick();
        branch_taken = 1'b0;
        repeat (6) tick();

        // Randomized traffic.
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            branch_taken = 1'b0;
            if (!rst_n) begin
                sb_reset();
            end else if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    do_branch(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                else
                    do_branch($urandom);
            end
            id_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(1, 4);
            tick();
        end
        rst_n        = 1'b1;
        branch_taken = 1'b0;
        id_stall     = 1'b0;
        repeat (10) tick();

        chk("sb_progress", {31'b0, (consumed > 300)}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
